// File: rtl/d_stage_decoder.sv
// Decode-stage controller for the 5-stage MIPS32 pipeline: registered hazard timing and D-stage control.
// Optional macro D_CTRL_EXT_BRANCH_EN adds bne (npc_slc=4) and jalr decoding.
module d_stage_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [1:0]  Tuse_rs,
  output logic [1:0]  Tuse_rt,
  output logic [1:0]  Tnew,
  output logic [4:0]  A3,
  output logic        regwrite,
  output logic        extop,
  output logic        luiop,
  output logic        beqop,
  output logic [2:0]  npc_slc,
  output logic        jalop,
  output logic        jop,
  output logic        jrop
);

  typedef struct packed {
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew;
    logic [4:0] a3;
    logic       regwrite;
    logic       extop;
    logic       luiop;
    logic       beqop;
    logic [2:0] npc_slc;
    logic       jalop;
    logic       jop;
    logic       jrop;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam ctrl_t CTRL_NOP = '{
    tuse_rs: 2'b11, tuse_rt: 2'b11, tnew: 2'b00, a3: 5'd0,
    regwrite: 1'b0, extop: 1'b0, luiop: 1'b0, beqop: 1'b0,
    npc_slc: 3'd0, jalop: 1'b0, jop: 1'b0, jrop: 1'b0
  };

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       instr_unused_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_r;

  assign op_s    = instr[31:26];
  assign funct_s = instr[5:0];
  assign rt_s    = instr[20:16];
  assign rd_s    = instr[15:11];
  // rs and shamt fields never influence decode
  assign instr_unused_s = ^{instr[25:21], instr[10:6]};

  // Combinational decode of the D-stage instruction word
  always_comb begin
    ctrl_s = CTRL_NOP;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADDU, FN_SUBU: begin
            ctrl_s.tuse_rs  = 2'd1;
            ctrl_s.tuse_rt  = 2'd1;
            ctrl_s.tnew     = 2'd1;
            ctrl_s.a3       = rd_s;
            ctrl_s.regwrite = 1'b1;
          end
          FN_JR: begin
            ctrl_s.tuse_rs = 2'd0;
            ctrl_s.npc_slc = 3'd3;
            ctrl_s.jrop    = 1'b1;
          end
`ifdef D_CTRL_EXT_BRANCH_EN
          FN_JALR: begin
            ctrl_s.tuse_rs  = 2'd0;
            ctrl_s.a3       = rd_s;
            ctrl_s.regwrite = 1'b1;
            ctrl_s.jalop    = 1'b1;
            ctrl_s.jrop     = 1'b1;
            ctrl_s.npc_slc  = 3'd3;
          end
`endif
          default: ctrl_s = CTRL_NOP;
        endcase
      end
      OP_ORI: begin
        ctrl_s.tuse_rs  = 2'd1;
        ctrl_s.tnew     = 2'd1;
        ctrl_s.a3       = rt_s;
        ctrl_s.regwrite = 1'b1;
      end
      OP_LW: begin
        ctrl_s.tuse_rs  = 2'd1;
        ctrl_s.tnew     = 2'd2;
        ctrl_s.a3       = rt_s;
        ctrl_s.regwrite = 1'b1;
        ctrl_s.extop    = 1'b1;
      end
      OP_SW: begin
        ctrl_s.tuse_rs = 2'd1;
        ctrl_s.tuse_rt = 2'd2;
        ctrl_s.extop   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_s.tuse_rs = 2'd0;
        ctrl_s.tuse_rt = 2'd0;
        ctrl_s.extop   = 1'b1;
        ctrl_s.beqop   = 1'b1;
        ctrl_s.npc_slc = 3'd1;
      end
`ifdef D_CTRL_EXT_BRANCH_EN
      OP_BNE: begin
        ctrl_s.tuse_rs = 2'd0;
        ctrl_s.tuse_rt = 2'd0;
        ctrl_s.extop   = 1'b1;
        ctrl_s.npc_slc = 3'd4;
      end
`endif
      OP_LUI: begin
        ctrl_s.tnew     = 2'd1;
        ctrl_s.a3       = rt_s;
        ctrl_s.regwrite = 1'b1;
        ctrl_s.luiop    = 1'b1;
      end
      OP_J: begin
        ctrl_s.npc_slc = 3'd2;
        ctrl_s.jop     = 1'b1;
      end
      OP_JAL: begin
        ctrl_s.a3       = 5'd31;
        ctrl_s.regwrite = 1'b1;
        ctrl_s.npc_slc  = 3'd2;
        ctrl_s.jalop    = 1'b1;
        ctrl_s.jop      = 1'b1;
      end
      default: ctrl_s = CTRL_NOP;
    endcase
  end

  // Capture register: reset forces the NOP pattern regardless of instr
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_r <= CTRL_NOP;
    end else begin
      ctrl_r <= ctrl_s;
    end
  end

  assign Tuse_rs  = ctrl_r.tuse_rs;
  assign Tuse_rt  = ctrl_r.tuse_rt;
  assign Tnew     = ctrl_r.tnew;
  assign A3       = ctrl_r.a3;
  assign regwrite = ctrl_r.regwrite;
  assign extop    = ctrl_r.extop;
  assign luiop    = ctrl_r.luiop;
  assign beqop    = ctrl_r.beqop;
  assign npc_slc  = ctrl_r.npc_slc;
  assign jalop    = ctrl_r.jalop;
  assign jop      = ctrl_r.jop;
  assign jrop     = ctrl_r.jrop;

endmodule

// File: tb/tb_d_stage_decoder.sv
// Scoreboard bench for d_stage_decoder: driver queues hand-computed expectations, monitor compares one cycle later.
module tb_d_stage_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [1:0]  Tuse_rs, Tuse_rt, Tnew;
  logic [4:0]  A3;
  logic        regwrite, extop, luiop, beqop, jalop, jop, jrop;
  logic [2:0]  npc_slc;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  string       name_q[$];
  logic [20:0] act_v;

  d_stage_decoder dut (
    .clk(clk), .reset(reset), .instr(instr),
    .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew(Tnew), .A3(A3),
    .regwrite(regwrite), .extop(extop), .luiop(luiop), .beqop(beqop),
    .npc_slc(npc_slc), .jalop(jalop), .jop(jop), .jrop(jrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack fields: rs,rt,tnew,a3,rw,ext,lui,beq,npc,jal,j,jr
  function automatic logic [20:0] ex(input logic [1:0] rs, input logic [1:0] rt,
      input logic [1:0] tn, input logic [4:0] a3, input logic rw, input logic ext,
      input logic lui, input logic beq, input logic [2:0] npc, input logic jal,
      input logic j, input logic jr);
    return {rs, rt, tn, a3, rw, ext, lui, beq, npc, jal, j, jr};
  endfunction

  function automatic logic [20:0] nop_exp();
    return ex(2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input string nm, input logic rst, input logic [31:0] w,
                       input logic [20:0] e);
    @(negedge clk);
    reset = rst;
    instr = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid just after the edge that captured the queued stimulus
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [20:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act_v = {Tuse_rs, Tuse_rt, Tnew, A3, regwrite, extop, luiop, beqop,
               npc_slc, jalop, jop, jrop};
      checks++;
      if (act_v !== e) begin
        errors++;
        $display("FAIL %s: got %06h required %06h (rs rt tnew a3 rw ext lui beq npc jal j jr)",
                 nm, act_v, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    instr = 32'h00430821;
    drive("reset_addu", 1'b0, 32'h00430821, nop_exp());
    drive("reset_hold", 1'b0, 32'h0C000010, nop_exp());
    drive("addu", 1'b1, 32'h00430821,
          ex(2'd1, 2'd1, 2'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("subu", 1'b1, 32'h00A62023,
          ex(2'd1, 2'd1, 2'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("addu_rd0", 1'b1, 32'h00430021,
          ex(2'd1, 2'd1, 2'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("ori", 1'b1, 32'h35071234,
          ex(2'd1, 2'd3, 2'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("lw", 1'b1, 32'h8C450004,
          ex(2'd1, 2'd3, 2'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("sw", 1'b1, 32'hAD490008,
          ex(2'd1, 2'd2, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("beq", 1'b1, 32'h10220003,
          ex(2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    drive("jal", 1'b1, 32'h0C000010,
          ex(2'd3, 2'd3, 2'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
    drive("lui", 1'b1, 32'h3C03ABCD,
          ex(2'd3, 2'd3, 2'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("j", 1'b1, 32'h08000010,
          ex(2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0));
    drive("jr", 1'b1, 32'h03E00008,
          ex(2'd0, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1));
    drive("all_ones", 1'b1, 32'hFFFFFFFF, nop_exp());
    drive("zero_word", 1'b1, 32'h00000000, nop_exp());
    drive("sll", 1'b1, 32'h000208C0, nop_exp());
`ifdef D_CTRL_EXT_BRANCH_EN
    drive("bne", 1'b1, 32'h14220003,
          ex(2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0));
    drive("jalr", 1'b1, 32'h0040F809,
          ex(2'd0, 2'd3, 2'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1));
`else
    drive("bne_off", 1'b1, 32'h14220003, nop_exp());
    drive("jalr_off", 1'b1, 32'h0040F809, nop_exp());
`endif
    drive("lw_again", 1'b1, 32'h8C450004,
          ex(2'd1, 2'd3, 2'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    drive("reset_mid_lw", 1'b0, 32'h8C450004, nop_exp());
    drive("after_reset_jr", 1'b1, 32'h03E00008,
          ex(2'd0, 2'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1));

    // Bounded drain of the scoreboard
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
